// File: rtl/matmul_job_sequencer.sv
// ----------------------------------------------------------------------------
// matmul_job_sequencer
//
// Control sequencer sitting in front of the matmul calc datapath. It accepts
// matrix-multiply job commands (dims minus one plus the add-previous-C mode
// bit), holds the calc block's level start high for the whole job, counts the
// C write-backs, and detects completion. Between jobs it forces exactly one
// cycle with start low so the calc block can rewind its loaders. One command
// can be buffered behind the running job. Sticky status and error bits are
// reported to the register file.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o is low only while the pending slot
// is occupied (and while reset is asserted); the offering side must hold the
// command stable until it transfers.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o        command handshake
//   cmd_n/k/m_dim_i, cmd_mode_i      command payload (dims minus one, mode)
//   calc_start_o                     level start to the calc block
//   calc_mode_o, calc_n/k/m_dim_o    active job, stable while start is high
//   calc_enable_w_i, calc_address_i  calc write-back strobe and address
//   calc_finish_mul_i, calc_flags_i  calc finish pulse and overflow flags
//   clear_i                          clears sticky status and errors
//   busy_o                           sequencer not idle
//   done_o                           one-cycle pulse per completed job
//   jobs_done_o                      completed-job counter (wraps)
//   status_flags_o                   sticky OR of flags captured at finish
//   err_timeout_o, err_dim_o, err_wb_o  sticky errors
//   state_o                          current FSM state (observation only)
// ----------------------------------------------------------------------------
module matmul_job_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_n_dim_i,
    input  logic [1:0]            cmd_k_dim_i,
    input  logic [1:0]            cmd_m_dim_i,
    input  logic                  cmd_mode_i,
    output logic                  calc_start_o,
    output logic                  calc_mode_o,
    output logic [1:0]            calc_n_dim_o,
    output logic [1:0]            calc_k_dim_o,
    output logic [1:0]            calc_m_dim_o,
    input  logic                  calc_enable_w_i,
    input  logic [ADDR_WIDTH-1:0] calc_address_i,
    input  logic                  calc_finish_mul_i,
    input  logic [BUS_WIDTH-1:0]  calc_flags_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            jobs_done_o,
    output logic [BUS_WIDTH-1:0]  status_flags_o,
    output logic                  err_timeout_o,
    output logic                  err_dim_o,
    output logic                  err_wb_o,
    output logic [1:0]            state_o
);

    localparam int          MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
    localparam logic [31:0] DIM_LAST    = 32'(MAX_DIM - 1);
    // A complete job always writes back a full MAX_DIM x MAX_DIM tile of C.
    localparam logic [8:0]  WB_TARGET   = 9'(MAX_DIM * MAX_DIM);
    localparam logic [7:0]  TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  WB_ADDR_TAG = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ABORT   = 2'd3
    } state_t;

    state_t     state;
    logic       pend_valid;
    logic [6:0] pend_word;      // {mode, n, k, m}
    logic [7:0] wb_cnt;         // saturating write-back count for this job
    logic [7:0] tmo_cnt;        // cycles spent in RUN for this job

    logic [6:0] cmd_word;
    logic [6:0] launch_word;
    logic       accept;
    logic       cmd_legal;
    logic       take_legal;
    logic       take_illegal;
    logic       in_gap;
    logic       launch;
    logic       addr_bad;
    logic [8:0] wb_total;
    logic       addr_unused;

    assign cmd_ready_o  = ~pend_valid & ~rst_i;
    assign accept       = cmd_valid_i & cmd_ready_o;
    assign cmd_word     = {cmd_mode_i, cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i};

    assign cmd_legal    = ({30'd0, cmd_n_dim_i} <= DIM_LAST) &&
                          ({30'd0, cmd_k_dim_i} <= DIM_LAST) &&
                          ({30'd0, cmd_m_dim_i} <= DIM_LAST);

    assign take_legal   = accept & cmd_legal;
    assign take_illegal = accept & ~cmd_legal;

    // RELEASE and ABORT are the one-cycle start-low gap; both exit the same way.
    assign in_gap       = (state == ST_RELEASE) || (state == ST_ABORT);

    // A job is launched straight into RUN from IDLE on a legal accept, or at
    // the end of the gap when either a pending command exists or a new legal
    // command arrives in that same cycle. The pending slot always has
    // priority; while it is full cmd_ready_o is low, so both cannot coincide.
    assign launch       = (take_legal & (state == ST_IDLE)) |
                          (in_gap & (pend_valid | take_legal));
    assign launch_word  = pend_valid ? pend_word : cmd_word;

    assign addr_bad     = calc_enable_w_i & (calc_address_i[4:0] != WB_ADDR_TAG);

    // Count including a strobe landing in the same cycle as the finish pulse.
    assign wb_total     = {1'b0, wb_cnt} + {8'd0, calc_enable_w_i};

    // Only the low address bits carry the write-back tag.
    assign addr_unused  = ^calc_address_i[ADDR_WIDTH-1:5];

    assign state_o      = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            pend_valid     <= 1'b0;
            pend_word      <= '0;
            wb_cnt         <= '0;
            tmo_cnt        <= '0;
            calc_start_o   <= 1'b0;
            calc_mode_o    <= 1'b0;
            calc_n_dim_o   <= '0;
            calc_k_dim_o   <= '0;
            calc_m_dim_o   <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            jobs_done_o    <= '0;
            status_flags_o <= '0;
            err_timeout_o  <= 1'b0;
            err_dim_o      <= 1'b0;
            err_wb_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // Clear first; any set below in the same cycle overrides it.
            if (clear_i) begin
                status_flags_o <= '0;
                err_timeout_o  <= 1'b0;
                err_dim_o      <= 1'b0;
                err_wb_o       <= 1'b0;
            end

            // Illegal commands are consumed and dropped without a state change.
            if (take_illegal) begin
                err_dim_o <= 1'b1;
            end

            if (launch) begin
                state        <= ST_RUN;
                busy_o       <= 1'b1;
                calc_start_o <= 1'b1;
                {calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o} <= launch_word;
                pend_valid   <= 1'b0;
                wb_cnt       <= '0;
                tmo_cnt      <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (take_legal) begin
                            pend_word  <= cmd_word;
                            pend_valid <= 1'b1;
                        end

                        if (calc_enable_w_i) begin
                            if (wb_cnt != 8'hFF) begin
                                wb_cnt <= wb_cnt + 8'd1;
                            end
                            if (addr_bad) begin
                                err_wb_o <= 1'b1;
                            end
                        end

                        // Finish takes priority over a coincident timeout.
                        if (calc_finish_mul_i) begin
                            state          <= ST_RELEASE;
                            calc_start_o   <= 1'b0;
                            done_o         <= 1'b1;
                            jobs_done_o    <= jobs_done_o + 8'd1;
                            status_flags_o <= (clear_i ? '0 : status_flags_o) | calc_flags_i;
                            if (wb_total != WB_TARGET) begin
                                err_wb_o <= 1'b1;
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            state         <= ST_ABORT;
                            calc_start_o  <= 1'b0;
                            err_timeout_o <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end

                    ST_RELEASE, ST_ABORT: begin
                        // Nothing to launch: the gap ends in IDLE.
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end

                    default: begin
                        // IDLE without a legal command: hold.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// ----------------------------------------------------------------------------
// tb_matmul_job_sequencer
//
// Drives directed job scenarios and a randomized phase into
// matmul_job_sequencer and compares every output, every cycle, against a
// job-level reference model (running/gap flags, a pending-command queue and
// plain counters).
// ----------------------------------------------------------------------------
module tb_matmul_job_sequencer;

    localparam int DW      = 8;
    localparam int BW      = 16;
    localparam int AW      = 32;
    localparam int TMO     = 255;
    localparam int MAX_DIM = BW / DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_n_dim_i = '0;
    logic [1:0]    cmd_k_dim_i = '0;
    logic [1:0]    cmd_m_dim_i = '0;
    logic          cmd_mode_i = 1'b0;
    logic          calc_start_o;
    logic          calc_mode_o;
    logic [1:0]    calc_n_dim_o;
    logic [1:0]    calc_k_dim_o;
    logic [1:0]    calc_m_dim_o;
    logic          calc_enable_w_i = 1'b0;
    logic [AW-1:0] calc_address_i = '0;
    logic          calc_finish_mul_i = 1'b0;
    logic [BW-1:0] calc_flags_i = '0;
    logic          clear_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [7:0]    jobs_done_o;
    logic [BW-1:0] status_flags_o;
    logic          err_timeout_o;
    logic          err_dim_o;
    logic          err_wb_o;
    logic [1:0]    state_o;

    matmul_job_sequencer #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_n_dim_i(cmd_n_dim_i), .cmd_k_dim_i(cmd_k_dim_i),
        .cmd_m_dim_i(cmd_m_dim_i), .cmd_mode_i(cmd_mode_i),
        .calc_start_o(calc_start_o), .calc_mode_o(calc_mode_o),
        .calc_n_dim_o(calc_n_dim_o), .calc_k_dim_o(calc_k_dim_o),
        .calc_m_dim_o(calc_m_dim_o),
        .calc_enable_w_i(calc_enable_w_i), .calc_address_i(calc_address_i),
        .calc_finish_mul_i(calc_finish_mul_i), .calc_flags_i(calc_flags_i),
        .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o),
        .jobs_done_o(jobs_done_o), .status_flags_o(status_flags_o),
        .err_timeout_o(err_timeout_o), .err_dim_o(err_dim_o),
        .err_wb_o(err_wb_o), .state_o(state_o)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Commands are {mode, n, k, m}. exp_q holds the buffered (pending) command.
    logic [6:0]    exp_q[$];
    logic [6:0]    m_act = '0;
    bit            m_run = 0;
    bit            m_gap = 0;
    int            m_age = 0;
    int            m_wb = 0;
    int            m_jobs = 0;
    logic [BW-1:0] m_flags = '0;
    bit            m_tmo = 0;
    bit            m_dim = 0;
    bit            m_wbe = 0;
    bit            m_done = 0;

    function automatic logic [6:0] mk(input logic md, input logic [1:0] n,
                                      input logic [1:0] k, input logic [1:0] m);
        return {md, n, k, m};
    endfunction

    task automatic model_edge(input logic v, input logic [6:0] c, input logic en,
                              input logic [31:0] a, input logic fin,
                              input logic [BW-1:0] fl, input logic clr, input logic rs);
        bit acc;
        bit legal;
        if (rs) begin
            exp_q.delete();
            m_run = 0; m_gap = 0; m_age = 0; m_wb = 0; m_jobs = 0;
            m_flags = '0; m_tmo = 0; m_dim = 0; m_wbe = 0; m_done = 0;
            return;
        end
        m_done = 0;
        acc   = v && (exp_q.size() == 0);
        legal = (int'(c[5:4]) < MAX_DIM) && (int'(c[3:2]) < MAX_DIM) && (int'(c[1:0]) < MAX_DIM);
        if (clr) begin
            m_flags = '0; m_tmo = 0; m_dim = 0; m_wbe = 0;
        end
        if (acc && !legal) m_dim = 1;
        if (m_run) begin
            if (acc && legal) exp_q.push_back(c);
            if (en) begin
                m_wb++;
                if ((a & 32'h1F) != 32'h10) m_wbe = 1;
            end
            m_age++;
            if (fin) begin
                m_run = 0; m_gap = 1; m_done = 1;
                m_jobs = (m_jobs + 1) % 256;
                m_flags = m_flags | fl;
                if (m_wb != MAX_DIM * MAX_DIM) m_wbe = 1;
            end else if (m_age == TMO) begin
                m_run = 0; m_gap = 1; m_tmo = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (exp_q.size() > 0) begin
                m_act = exp_q.pop_front();
                m_run = 1; m_age = 0; m_wb = 0;
            end else if (acc && legal) begin
                m_act = c;
                m_run = 1; m_age = 0; m_wb = 0;
            end
        end else if (acc && legal) begin
            m_act = c;
            m_run = 1; m_age = 0; m_wb = 0;
        end
    endtask

    task automatic check_outputs();
        check("calc_start", 32'(calc_start_o), 32'(m_run));
        check("busy", 32'(busy_o), 32'(m_run | m_gap));
        check("done", 32'(done_o), 32'(m_done));
        check("jobs_done", 32'(jobs_done_o), 32'(m_jobs));
        check("status_flags", 32'(status_flags_o), 32'(m_flags));
        check("err_timeout", 32'(err_timeout_o), 32'(m_tmo));
        check("err_dim", 32'(err_dim_o), 32'(m_dim));
        check("err_wb", 32'(err_wb_o), 32'(m_wbe));
        if (m_run)
            check("calc_cmd", 32'({calc_mode_o, calc_n_dim_o, calc_k_dim_o, calc_m_dim_o}), 32'(m_act));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drives one cycle of inputs, checks the
    // combinational ready, advances the model and the DUT by one rising edge,
    // then checks all registered outputs at the next falling edge.
    task automatic step(input logic v, input logic [6:0] c, input logic en,
                        input logic [31:0] a, input logic fin, input logic [BW-1:0] fl,
                        input logic clr, input logic rs, output bit acc);
        cmd_valid_i = v;
        {cmd_mode_i, cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i} = c;
        calc_enable_w_i = en;
        calc_address_i = a;
        calc_finish_mul_i = fin;
        calc_flags_i = fl;
        clear_i = clr;
        rst_i = rs;
        #1;
        check("cmd_ready", 32'(cmd_ready_o), 32'((exp_q.size() == 0) && !rs));
        acc = v && cmd_ready_o;
        model_edge(v, c, en, a, fin, fl, clr, rs);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        bit acc;
        step(1'b0, 7'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [6:0] c);
        bit acc;
        step(1'b1, c, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic calc(input logic en, input logic [31:0] a, input logic fin, input logic [BW-1:0] fl);
        bit acc;
        step(1'b0, 7'd0, en, a, fin, fl, 1'b0, 1'b0, acc);
    endtask

    task automatic clear_sticky();
        bit acc;
        step(1'b0, 7'd0, 1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic reset_dut();
        bit acc;
        step(1'b0, 7'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 7'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] cmds [3];
        int idx;
        int emu;
        int run_len;
        bit done_seen;
        bit acc;
        logic v, en, fin, clr, rs;
        logic [6:0] c;
        logic [31:0] a;
        logic [BW-1:0] fl;

        @(negedge clk);

        // Reset state and a single 2x2 job.
        reset_dut();
        check("rst_start", 32'(calc_start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_jobs", 32'(jobs_done_o), 32'd0);
        idle();
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        send(mk(1'b0, 2'd1, 2'd1, 2'd1));
        check("t1_start_edge0", 32'(calc_start_o), 32'd1);
        calc(1'b1, 32'h10, 1'b0, '0);
        calc(1'b1, 32'h30, 1'b0, '0);
        calc(1'b1, 32'h50, 1'b0, '0);
        calc(1'b1, 32'h70, 1'b0, '0);
        calc(1'b0, 32'h0, 1'b1, 16'h0005);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_start_low", 32'(calc_start_o), 32'd0);
        idle();
        check("t1_jobs", 32'(jobs_done_o), 32'd1);
        check("t1_flags", 32'(status_flags_o), 32'h5);
        check("t1_errs", 32'({err_timeout_o, err_dim_o, err_wb_o}), 32'd0);
        check("t1_idle", 32'(busy_o), 32'd0);

        // Three commands offered back to back against a well-behaved calc.
        reset_dut();
        cmds[0] = mk(1'b0, 2'd1, 2'd1, 2'd1);
        cmds[1] = mk(1'b1, 2'd0, 2'd1, 2'd0);
        cmds[2] = mk(1'b1, 2'd1, 2'd0, 2'd1);
        idx = 0;
        emu = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (idx == 3 && !m_run && !m_gap) break;
            if (calc_start_o) emu++; else emu = 0;
            v   = (idx < 3);
            c   = (idx < 3) ? cmds[idx] : 7'd0;
            en  = (emu >= 1) && (emu <= 4);
            a   = 32'h10 + 32'(32 * (emu > 0 ? emu - 1 : 0));
            fin = (emu == 5);
            step(v, c, en, a, fin, 16'h0100, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("t2_complete", 32'((idx == 3) && !busy_o), 32'd1);
        check("t2_jobs", 32'(jobs_done_o), 32'd3);
        check("t2_errs", 32'({err_timeout_o, err_dim_o, err_wb_o}), 32'd0);

        // Finish never arrives: abort after the timeout window.
        reset_dut();
        send(mk(1'b0, 2'd0, 2'd0, 2'd0));
        run_len = 0;
        done_seen = 0;
        if (calc_start_o) run_len++;
        for (int cyc = 0; cyc < 260; cyc++) begin
            idle();
            if (calc_start_o) run_len++;
            if (done_o) done_seen = 1;
        end
        check("t3_run_len", 32'(run_len), 32'(TMO));
        check("t3_err_timeout", 32'(err_timeout_o), 32'd1);
        check("t3_no_done", 32'(done_seen), 32'd0);
        check("t3_jobs", 32'(jobs_done_o), 32'd0);
        clear_sticky();
        check("t3_cleared", 32'(err_timeout_o), 32'd0);

        // Out-of-range dimension.
        send(mk(1'b0, 2'd2, 2'd0, 2'd0));
        check("t4_err_dim", 32'(err_dim_o), 32'd1);
        check("t4_no_start", 32'(calc_start_o), 32'd0);
        check("t4_not_busy", 32'(busy_o), 32'd0);
        clear_sticky();

        // Short write-back count, then a mis-tagged address.
        send(mk(1'b1, 2'd1, 2'd1, 2'd1));
        calc(1'b1, 32'h10, 1'b0, '0);
        calc(1'b1, 32'h30, 1'b0, '0);
        calc(1'b1, 32'h50, 1'b0, '0);
        calc(1'b0, 32'h0, 1'b1, 16'h8000);
        check("t5_short_done", 32'(done_o), 32'd1);
        check("t5_short_err_wb", 32'(err_wb_o), 32'd1);
        idle();
        clear_sticky();
        send(mk(1'b0, 2'd1, 2'd0, 2'd1));
        calc(1'b1, 32'h10, 1'b0, '0);
        calc(1'b1, 32'h08, 1'b0, '0);
        check("t5_addr_err_wb", 32'(err_wb_o), 32'd1);
        calc(1'b1, 32'h50, 1'b0, '0);
        calc(1'b1, 32'h70, 1'b1, '0);
        check("t5_addr_done", 32'(done_o), 32'd1);
        idle();

        // Reset in the middle of a job with the pending slot full.
        reset_dut();
        send(mk(1'b0, 2'd1, 2'd1, 2'd1));
        send(mk(1'b1, 2'd0, 2'd0, 2'd0));
        check("t6_pend_full", 32'(cmd_ready_o), 32'd0);
        step(1'b0, 7'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1, acc);
        check("t6_start_drop", 32'(calc_start_o), 32'd0);
        check("t6_busy_drop", 32'(busy_o), 32'd0);
        for (int cyc = 0; cyc < 5; cyc++) idle();
        check("t6_pend_dropped", 32'(calc_start_o), 32'd0);

        // Randomized phase.
        emu = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (calc_start_o) emu++; else emu = 0;
            v = ($urandom_range(0, 99) < 35);
            c[6] = 1'($urandom_range(0, 1));
            for (int d = 0; d < 3; d++) begin
                logic [1:0] dim;
                dim = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
                c[2*d +: 2] = dim;
            end
            en  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 19) != 0) a[4:0] = 5'b10000;
            fin = calc_start_o && (emu >= 2) && ($urandom_range(0, 5) == 0);
            fl  = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            clr = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            step(v, c, en, a, fin, fl, clr, rs, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
